// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module : button_pkg
// Shared gesture FSM state type, default cycle counts and counter sizing.
// Rev    : 1.0
// ============================================================================
package button_pkg;

   typedef enum logic [2:0] {
      GS_IDLE   = 3'd0,
      GS_PRESS1 = 3'd1,
      GS_GAP    = 3'd2,
      GS_PRESS2 = 3'd3,
      GS_HELD   = 3'd4
   } gesture_state_t;

   localparam int LONG_PRESS_DEFAULT = 12_000_000;
   localparam int DOUBLE_GAP_DEFAULT = 6_000_000;
   localparam int REPEAT_DEFAULT     = 3_000_000;
   localparam int CNT_W_DEFAULT      = 25;

   // Minimum counter width able to hold the largest of three cycle counts.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage : button_pkg
`default_nettype wire

// File: rtl/gesture_timer.sv
`default_nettype none
// ============================================================================
// Module : gesture_timer
// Loadable down-counter that stops at zero; `zero` flags an expired count.
// Rev    : 1.0
// ============================================================================
module gesture_timer #(
   parameter int CNT_W = 25
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign zero = (r_count == '0);

endmodule : gesture_timer
`default_nettype wire

// File: rtl/button_gesture_decoder.sv
`default_nettype none
// ============================================================================
// Module : button_gesture_decoder
// Classifies debounced press/release pulses into short, long, double click
// and (with BUTTON_HOLD_REPEAT_EN defined) auto-repeat while held.
// Rev    : 1.0
// ============================================================================
module button_gesture_decoder
   import button_pkg::*;
#(
   parameter int LONG_PRESS_CYCLES = LONG_PRESS_DEFAULT,
   parameter int DOUBLE_GAP_CYCLES = DOUBLE_GAP_DEFAULT,
   parameter int REPEAT_CYCLES     = REPEAT_DEFAULT,
   parameter int CNT_W             = CNT_W_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_pressed,
   input  logic button_released,
   output logic short_press,
   output logic long_press,
   output logic double_click,
   output logic hold_repeat,
   output logic busy
);

   // Press/release windows include the cycle of the sampled edge itself, so
   // the timer runs one cycle shorter than the window once the state is entered.
   localparam logic [CNT_W-1:0] c_LONG_LOAD = CNT_W'(LONG_PRESS_CYCLES - 2);
   localparam logic [CNT_W-1:0] c_GAP_LOAD  = CNT_W'(DOUBLE_GAP_CYCLES - 2);
`ifdef BUTTON_HOLD_REPEAT_EN
   localparam logic [CNT_W-1:0] c_HELD_LOAD = CNT_W'(REPEAT_CYCLES - 1);
`else
   localparam logic [CNT_W-1:0] c_HELD_LOAD = '0;
`endif

   if ((LONG_PRESS_CYCLES < 2) || (DOUBLE_GAP_CYCLES < 2) || (REPEAT_CYCLES < 1) ||
       (CNT_W < cnt_width(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES, REPEAT_CYCLES))) begin : g_bad_params
      $error("button_gesture_decoder: cycle counts out of range for CNT_W");
   end

   gesture_state_t   r_state;
   gesture_state_t   w_state_nxt;
   logic             w_press;
   logic             w_release;
   logic             w_zero;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_short;
   logic             w_long;
   logic             w_double;
   logic             w_repeat;
   logic             r_short;
   logic             r_long;
   logic             r_double;
   logic             r_busy;

   // Simultaneous press and release is treated as no edge at all.
   assign w_press   = button_pressed  & ~button_released;
   assign w_release = button_released & ~button_pressed;

   gesture_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_load),
      .load_val (w_load_val),
      .zero     (w_zero)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_val  = '0;
      w_short     = 1'b0;
      w_long      = 1'b0;
      w_double    = 1'b0;
      w_repeat    = 1'b0;
      case (r_state)
         GS_IDLE: begin
            if (w_press) begin
               w_state_nxt = GS_PRESS1;
               w_load      = 1'b1;
               w_load_val  = c_LONG_LOAD;
            end
         end
         GS_PRESS1: begin
            if (w_release) begin
               w_state_nxt = GS_GAP;
               w_load      = 1'b1;
               w_load_val  = c_GAP_LOAD;
            end else if (w_zero) begin
               w_long      = 1'b1;
               w_state_nxt = GS_HELD;
               w_load      = 1'b1;
               w_load_val  = c_HELD_LOAD;
            end
         end
         GS_GAP: begin
            if (w_press) begin
               w_double    = 1'b1;
               w_state_nxt = GS_PRESS2;
               w_load      = 1'b1;
            end else if (w_zero) begin
               w_short     = 1'b1;
               w_state_nxt = GS_IDLE;
               w_load      = 1'b1;
            end
         end
         GS_PRESS2: begin
            if (w_release) begin
               w_state_nxt = GS_IDLE;
               w_load      = 1'b1;
            end
         end
         GS_HELD: begin
            if (w_release) begin
               w_state_nxt = GS_IDLE;
               w_load      = 1'b1;
            end
`ifdef BUTTON_HOLD_REPEAT_EN
            else if (w_zero) begin
               w_repeat    = 1'b1;
               w_load      = 1'b1;
               w_load_val  = c_HELD_LOAD;
            end
`endif
         end
         default: begin
            w_state_nxt = GS_IDLE;
            w_load      = 1'b1;
         end
      endcase
   end

   // busy stays up through the cycle that carries the final pulse of a gesture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= GS_IDLE;
         r_short  <= 1'b0;
         r_long   <= 1'b0;
         r_double <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_short  <= w_short;
         r_long   <= w_long;
         r_double <= w_double;
         r_busy   <= (w_state_nxt != GS_IDLE) | w_short | w_long | w_double | w_repeat;
      end
   end

`ifdef BUTTON_HOLD_REPEAT_EN
   logic r_repeat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_repeat <= 1'b0;
      end else begin
         r_repeat <= w_repeat;
      end
   end

   assign hold_repeat = r_repeat;
`else
   assign hold_repeat = 1'b0;
`endif

   assign short_press  = r_short;
   assign long_press   = r_long;
   assign double_click = r_double;
   assign busy         = r_busy;

endmodule : button_gesture_decoder
`default_nettype wire

// File: tb/tb_button_gesture_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_button_gesture_decoder
// Scoreboard bench for button_gesture_decoder with LONG=8, GAP=4, REPEAT=3.
// Rev    : 1.0
// ============================================================================
module tb_button_gesture_decoder;

   localparam int c_LONG   = 8;
   localparam int c_GAP    = 4;
   localparam int c_REPEAT = 3;
   localparam int c_CNT_W  = 8;

   localparam int K_SHORT  = 0;
   localparam int K_LONG   = 1;
   localparam int K_DOUBLE = 2;
   localparam int K_REPEAT = 3;

   typedef struct {
      int cyc;
      int kind;
   } exp_t;

   logic clk;
   logic rst_n;
   logic button_pressed;
   logic button_released;
   logic short_press;
   logic long_press;
   logic double_click;
   logic hold_repeat;
   logic busy;

   int   checks;
   int   errors;
   int   tcyc;
   exp_t sb[$];
   logic busy_log [0:32];

   button_gesture_decoder #(
      .LONG_PRESS_CYCLES (c_LONG),
      .DOUBLE_GAP_CYCLES (c_GAP),
      .REPEAT_CYCLES     (c_REPEAT),
      .CNT_W             (c_CNT_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .button_pressed  (button_pressed),
      .button_released (button_released),
      .short_press     (short_press),
      .long_press      (long_press),
      .double_click    (double_click),
      .hold_repeat     (hold_repeat),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every output pulse must match the oldest queued expectation.
   always @(posedge clk) begin : p_monitor
      int   n;
      int   kind;
      exp_t e;
      #1;
      tcyc = tcyc + 1;
      n = int'(short_press) + int'(long_press) + int'(double_click) + int'(hold_repeat);
      if (n != 0) begin
         if (short_press)       kind = K_SHORT;
         else if (long_press)   kind = K_LONG;
         else if (double_click) kind = K_DOUBLE;
         else                   kind = K_REPEAT;
         checks++;
         if (n > 1) begin
            errors++;
            $display("FAIL multi_pulse: %0d pulses at cycle %0d, required at most 1", n, tcyc);
         end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required none", kind, tcyc);
         end else begin
            e = sb.pop_front();
            if ((e.cyc != tcyc) || (e.kind != kind)) begin
               errors++;
               $display("FAIL pulse_match: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                        kind, tcyc, e.kind, e.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic expect_pulse(input int cyc, input int kind);
      exp_t e;
      e.cyc  = cyc;
      e.kind = kind;
      sb.push_back(e);
   endtask

   // Drives one input pair per cycle starting at the current negedge.
   task automatic play(input int len, input logic [31:0] pmask, input logic [31:0] rmask);
      for (int k = 0; k < len; k++) begin
         button_pressed  = pmask[k];
         button_released = rmask[k];
         @(negedge clk);
         busy_log[k+1] = busy;
      end
      button_pressed  = 1'b0;
      button_released = 1'b0;
   endtask

   task automatic test_reset();
      rst_n           = 1'b0;
      button_pressed  = 1'b0;
      button_released = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (short_press !== 1'b0) begin errors++; $display("FAIL reset_short: got %b, required 0", short_press); end
      checks++;
      if (long_press !== 1'b0) begin errors++; $display("FAIL reset_long: got %b, required 0", long_press); end
      checks++;
      if (double_click !== 1'b0) begin errors++; $display("FAIL reset_double: got %b, required 0", double_click); end
      checks++;
      if (hold_repeat !== 1'b0) begin errors++; $display("FAIL reset_repeat: got %b, required 0", hold_repeat); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
   endtask

   task automatic test_short();
      int base;
      @(negedge clk);
      base = tcyc;
      expect_pulse(base + 7, K_SHORT);
      play(12, 32'h1, 32'h8);
      for (int k = 1; k <= 12; k++) begin
         checks++;
         if (busy_log[k] !== ((k <= 7) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL short_busy: cycle %0d got %b, required %b", k, busy_log[k], (k <= 7));
         end
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL short_missing: %0d pulses pending, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_long();
      int base;
      @(negedge clk);
      base = tcyc;
      expect_pulse(base + 8, K_LONG);
`ifdef BUTTON_HOLD_REPEAT_EN
      expect_pulse(base + 11, K_REPEAT);
      expect_pulse(base + 14, K_REPEAT);
      expect_pulse(base + 17, K_REPEAT);
      expect_pulse(base + 20, K_REPEAT);
`endif
      play(26, 32'h1, 32'h0010_0000);
      checks++;
      if (busy_log[20] !== 1'b1) begin errors++; $display("FAIL long_busy_held: got %b, required 1", busy_log[20]); end
      checks++;
      if (busy_log[21] !== 1'b0) begin errors++; $display("FAIL long_busy_drop: got %b, required 0", busy_log[21]); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL long_missing: %0d pulses pending, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_double();
      int base;
      @(negedge clk);
      base = tcyc;
      expect_pulse(base + 5, K_DOUBLE);
      play(14, 32'h11, 32'h44);
      checks++;
      if (busy_log[6] !== 1'b1) begin errors++; $display("FAIL double_busy_held: got %b, required 1", busy_log[6]); end
      checks++;
      if (busy_log[7] !== 1'b0) begin errors++; $display("FAIL double_busy_drop: got %b, required 0", busy_log[7]); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL double_missing: %0d pulses pending, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_boundaries();
      int base;
      // Second press in the last gap cycle is still a double click.
      @(negedge clk);
      base = tcyc;
      expect_pulse(base + 7, K_DOUBLE);
      play(14, 32'h41, 32'h108);
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL gap_edge_missing: %0d pending, required 0", sb.size()); sb.delete(); end
      // Release in the long-press expiry cycle gives a short press instead.
      @(negedge clk);
      base = tcyc;
      expect_pulse(base + 11, K_SHORT);
      play(16, 32'h1, 32'h80);
      checks++;
      if (busy_log[11] !== 1'b1) begin errors++; $display("FAIL long_edge_busy: got %b, required 1", busy_log[11]); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL long_edge_missing: %0d pending, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_ignored_inputs();
      play(12, 32'h1, 32'h1);
      for (int k = 1; k <= 12; k++) begin
         checks++;
         if (busy_log[k] !== 1'b0) begin errors++; $display("FAIL both_busy: cycle %0d got %b, required 0", k, busy_log[k]); end
      end
      play(12, 32'h0, 32'h1);
      for (int k = 1; k <= 12; k++) begin
         checks++;
         if (busy_log[k] !== 1'b0) begin errors++; $display("FAIL stray_release_busy: cycle %0d got %b, required 0", k, busy_log[k]); end
      end
   endtask

   task automatic test_reset_abort();
      int base;
      @(negedge clk);
      button_pressed = 1'b1;
      @(negedge clk);
      button_pressed = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b, required 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({short_press, long_press, double_click, hold_repeat, busy} !== 5'b0) begin
         errors++;
         $display("FAIL abort_outputs: got %b, required 00000",
                  {short_press, long_press, double_click, hold_repeat, busy});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: step %0d got %b, required 0", k, busy); end
      end
      @(negedge clk);
      base = tcyc;
      expect_pulse(base + 5, K_SHORT);
      play(10, 32'h1, 32'h2);
      checks++;
      if (busy_log[5] !== 1'b1) begin errors++; $display("FAIL abort_fresh_busy: got %b, required 1", busy_log[5]); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL abort_fresh_missing: %0d pending, required 0", sb.size()); sb.delete(); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      tcyc   = 0;
      test_reset();
      test_short();
      test_long();
      test_double();
      test_boundaries();
      test_ignored_inputs();
      test_reset_abort();
      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_button_gesture_decoder
`default_nettype wire
